// File: rtl/rr_mux2_arbiter.sv
// Round-robin arbiter for two valid/ready sources feeding a one-entry registered output.
// Define RR_MUX2_STATS_EN to add saturating per-source grant counters with a synchronous clear.
module rr_mux2_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a0_valid,
    input  logic [WIDTH-1:0] a0_data,
    output logic             a0_ready,
    input  logic             a1_valid,
    input  logic [WIDTH-1:0] a1_data,
    output logic             a1_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             s
`ifdef RR_MUX2_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      cnt_a0,
    output logic [15:0]      cnt_a1
`endif
);

    // Handshake: a word moves on any port exactly when valid & ready are both high at a
    // rising clk edge; ready may depend on valid, valid never depends on ready.

    logic can_load;
    logic grant_a0;
    logic grant_a1;
    logic last_grant;

    always_comb begin
        can_load = !y_valid || y_ready;
        grant_a0 = 1'b0;
        grant_a1 = 1'b0;
        if (can_load) begin
            // On contention the source that did not win last time goes next.
            if (a0_valid && a1_valid) begin
                grant_a0 = last_grant;
                grant_a1 = !last_grant;
            end else begin
                grant_a0 = a0_valid;
                grant_a1 = a1_valid;
            end
        end
    end

    assign a0_ready = grant_a0;
    assign a1_ready = grant_a1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid    <= 1'b0;
            y_data     <= '0;
            s          <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_a0) begin
            y_valid    <= 1'b1;
            y_data     <= a0_data;
            s          <= 1'b0;
            last_grant <= 1'b0;
        end else if (grant_a1) begin
            y_valid    <= 1'b1;
            y_data     <= a1_data;
            s          <= 1'b1;
            last_grant <= 1'b1;
        end else if (y_ready) begin
            y_valid    <= 1'b0;
        end
    end

`ifdef RR_MUX2_STATS_EN
    // Counters stick at all-ones instead of wrapping; clear wins over a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a0 <= '0;
            cnt_a1 <= '0;
        end else if (cnt_clr) begin
            cnt_a0 <= '0;
            cnt_a1 <= '0;
        end else begin
            if (grant_a0 && (cnt_a0 != 16'hFFFF)) cnt_a0 <= cnt_a0 + 16'd1;
            if (grant_a1 && (cnt_a1 != 16'hFFFF)) cnt_a1 <= cnt_a1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Self-checking bench for rr_mux2_arbiter: behavioural grant model plus a queue of
// expected output words (select bit concatenated with payload).
module tb_rr_mux2_arbiter;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a0_valid, a1_valid, y_ready;
    logic [WIDTH-1:0] a0_data, a1_data;
    logic             a0_ready, a1_ready, y_valid, s;
    logic [WIDTH-1:0] y_data;
`ifdef RR_MUX2_STATS_EN
    logic             cnt_clr;
    logic [15:0]      cnt_a0, cnt_a1;
`endif

    rr_mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a0_valid(a0_valid), .a0_data(a0_data), .a0_ready(a0_ready),
        .a1_valid(a1_valid), .a1_data(a1_data), .a1_ready(a1_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready), .s(s)
`ifdef RR_MUX2_STATS_EN
        , .cnt_clr(cnt_clr), .cnt_a0(cnt_a0), .cnt_a1(cnt_a1)
`endif
    );

    always #5 clk = ~clk;

    // scoreboard and model state
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] cur;
    logic           m_yv, m_last;
    logic           last_g0, last_g1;
    int             n_vec = 0;
    int             n_err = 0;

    function automatic void model_grant(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_yv || y_ready) begin
            case ({a1_valid, a0_valid})
                2'b01: g0 = 1'b1;
                2'b10: g1 = 1'b1;
                2'b11: begin g0 = m_last; g1 = !m_last; end
                default: ;
            endcase
        end
    endfunction

    // One clock: inputs are sampled by the model at the falling edge, outputs settle #1 after rise.
    task automatic tick();
        logic g0, g1;
        @(negedge clk);
        model_grant(g0, g1);
        last_g0 = g0;
        last_g1 = g1;
        if (g0) begin
            exp_q.push_back({1'b0, a0_data});
            m_last = 1'b0;
            m_yv = 1'b1;
        end else if (g1) begin
            exp_q.push_back({1'b1, a1_data});
            m_last = 1'b1;
            m_yv = 1'b1;
        end else if (y_ready) begin
            m_yv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_yv = 1'b0;
        m_last = 1'b1;
        cur = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        a0_valid = 0; a1_valid = 0; y_ready = 0;
        a0_data = '0; a1_data = '0;
        rst_n = 0;
`ifdef RR_MUX2_STATS_EN
        cnt_clr = 0;
`endif
        model_reset();
        #3;
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_init: got v=%b s=%b d=%h want 0 0 00", y_valid, s, y_data);
        end
        #9 rst_n = 1;
        // load a word, then reset in the middle of a cycle while it is held
        a0_valid = 1; a0_data = 8'h77;
        tick();
        a0_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b1, cur}) begin
            n_err++;
            $display("FAIL reset_load: got v=%b s=%b d=%h want 1 %h", y_valid, s, y_data, cur);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        n_vec++;
        if ({y_valid, s, y_data, a0_ready, a1_ready} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b s=%b d=%h r=%b%b want all 0",
                     y_valid, s, y_data, a0_ready, a1_ready);
        end
        #2 rst_n = 1;
        // first contention after reset must go to A0
        @(posedge clk); #1;
        a0_valid = 1; a0_data = 8'h11; a1_valid = 1; a1_data = 8'h22; y_ready = 1;
        #1;
        n_vec++;
        if ({a0_ready, a1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_first_grant: got r=%b%b want 10", a0_ready, a1_ready);
        end
        tick();
        a0_valid = 0; a1_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b1, 1'b0, 8'h11}) begin
            n_err++;
            $display("FAIL reset_first_word: got v=%b s=%b d=%h want 1 0 11", y_valid, s, y_data);
        end
        tick();
    endtask

    task automatic test_single();
        a0_valid = 1; a0_data = 8'h3C; a1_valid = 0; y_ready = 1;
        #1;
        n_vec++;
        if ({a0_ready, a1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL single_ready: got r=%b%b want 10", a0_ready, a1_ready);
        end
        tick();
        a0_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({y_valid, s, y_data, a1_ready} !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin
            n_err++;
            $display("FAIL single_out: got v=%b s=%b d=%h r1=%b want 1 0 3c 0",
                     y_valid, s, y_data, a1_ready);
        end
    endtask

    task automatic test_fairness();
        logic g0, g1;
        a0_valid = 1; a0_data = 8'hA0; a1_valid = 1; a1_data = 8'hA1; y_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            model_grant(g0, g1);
            n_vec++;
            if ({a0_ready, a1_ready} !== {g0, g1}) begin
                n_err++;
                $display("FAIL fair_ready[%0d]: got %b%b want %b%b", i, a0_ready, a1_ready, g0, g1);
            end
            tick();
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            n_vec++;
            // last winner was A0 before this test, so the sequence starts on A1 then alternates
            if ({y_valid, s, y_data} !== {1'b1, cur} || s !== ((i % 2) == 0)) begin
                n_err++;
                $display("FAIL fair_out[%0d]: got v=%b s=%b d=%h want 1 %h", i, y_valid, s, y_data, cur);
            end
        end
        a0_valid = 0; a1_valid = 0;
        tick();
        n_vec++;
        if (y_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fair_drain: got v=%b want 0", y_valid);
        end
    endtask

    task automatic test_backpressure();
        a0_valid = 1; a0_data = 8'h55; y_ready = 1;
        tick();
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        y_ready = 0; a1_valid = 1; a1_data = 8'hA1; a0_data = 8'hA0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({a0_ready, a1_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", i, a0_ready, a1_ready);
            end
            tick();
            n_vec++;
            if ({y_valid, s, y_data} !== {1'b1, 1'b0, 8'h55} || exp_q.size() != 0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%b d=%h want 1 0 55", i, y_valid, s, y_data);
            end
        end
        y_ready = 1;
        #1;
        n_vec++;
        if ({a0_ready, a1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got r=%b%b want 01", a0_ready, a1_ready);
        end
        tick();
        a0_valid = 0; a1_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b1, 1'b1, 8'hA1}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b s=%b d=%h want 1 1 a1", y_valid, s, y_data);
        end
    endtask

    task automatic test_drain();
        y_ready = 1;
        tick();
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b0, cur}) begin
            n_err++;
            $display("FAIL drain_empty: got v=%b s=%b d=%h want 0 %h", y_valid, s, y_data, cur);
        end
        tick();
        a1_valid = 1; a1_data = 8'h5A;
        tick();
        a1_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({y_valid, s, y_data} !== {1'b1, 1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL drain_refill: got v=%b s=%b d=%h want 1 1 5a", y_valid, s, y_data);
        end
    endtask

    task automatic test_random();
        logic g0, g1;
        a0_valid = 0; a1_valid = 0;
        for (int i = 0; i < 300; i++) begin
            // sources hold valid/data until accepted
            if (!a0_valid || last_g0) begin
                a0_valid = 1'($urandom_range(0, 1));
                a0_data = 8'($urandom_range(0, 255));
            end
            if (!a1_valid || last_g1) begin
                a1_valid = 1'($urandom_range(0, 1));
                a1_data = 8'($urandom_range(0, 255));
            end
            y_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_grant(g0, g1);
            n_vec++;
            if ({a0_ready, a1_ready} !== {g0, g1}) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, a0_ready, a1_ready, g0, g1);
            end
            tick();
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            n_vec++;
            if ({y_valid, s, y_data} !== {m_yv, cur}) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got v=%b s=%b d=%h want %b %h", i, y_valid, s, y_data, m_yv, cur);
            end
        end
        a0_valid = 0; a1_valid = 0; y_ready = 1;
        tick();
    endtask

`ifdef RR_MUX2_STATS_EN
    task automatic test_stats();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        a0_valid = 1; a0_data = 8'h01; a1_valid = 0; y_ready = 1;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (exp_q.size() > 0) cur = exp_q.pop_front();
        end
        n_vec++;
        if ({cnt_a0, cnt_a1} !== {16'hFFFF, 16'h0000}) begin
            n_err++;
            $display("FAIL stats_sat: got a0=%h a1=%h want ffff 0000", cnt_a0, cnt_a1);
        end
        cnt_clr = 1;
        tick();
        cnt_clr = 0; a0_valid = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        n_vec++;
        if ({cnt_a0, cnt_a1, y_valid} !== {16'h0000, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL stats_clr: got a0=%h a1=%h v=%b want 0000 0000 1", cnt_a0, cnt_a1, y_valid);
        end
        tick();
    endtask
`endif

    initial begin
        last_g0 = 0;
        last_g1 = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_drain();
        test_random();
`ifdef RR_MUX2_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
